// File: rtl/axi_2p_mem.sv
// AXI4 two-port memory: independent write and read FSMs over a byte-strobed word array.
// rvalid one cycle after AR, one beat/cycle, registered rdata holds under rready=0; reads see pre-write data.
module axi_2p_mem #(
  parameter int    G_DATAWIDTH = 32,
  parameter int    G_MEMDEPTH  = 1024,
  parameter int    G_ID_WIDTH  = 4,
  parameter string G_INIT_FILE = ""
) (
  input  logic                          s_aclk,
  input  logic                          s_areset,
  input  logic [G_ID_WIDTH-1:0]         s_axi_awid,
  input  logic [$clog2(G_MEMDEPTH)-1:0] s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [G_DATAWIDTH-1:0]        s_axi_wdata,
  input  logic [G_DATAWIDTH/8-1:0]      s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [G_ID_WIDTH-1:0]         s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [G_ID_WIDTH-1:0]         s_axi_arid,
  input  logic [$clog2(G_MEMDEPTH)-1:0] s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [G_ID_WIDTH-1:0]         s_axi_rid,
  output logic [G_DATAWIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);
  localparam int AW    = $clog2(G_MEMDEPTH);
  localparam int SB    = G_DATAWIDTH / 8;
  localparam int LB    = $clog2(SB);
  localparam int WORDS = G_MEMDEPTH / SB;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  logic [G_DATAWIDTH-1:0] mem_q [WORDS];

  initial begin
    for (int i = 0; i < WORDS; i++) mem_q[i] = '0;
  end

  // WRAP keeps the upper address bits and lets the low bits roll within the (len+1)*2^size window.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr, wmask, sum;
    incr  = 32'd1 << size;
    wmask = ((32'(len) + 32'd1) << size) - 32'd1;
    sum   = 32'(a) + incr;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) return AW'((32'(a) & ~wmask) | (sum & wmask));
    return AW'(sum);
  endfunction

  wstate_e               wstate_q, wstate_d;
  logic [G_ID_WIDTH-1:0] awid_q;
  logic [AW-1:0]         waddr_q;
  logic [7:0]            awlen_q, wcnt_q;
  logic [2:0]            awsize_q;
  logic [1:0]            awburst_q;
  logic                  aw_hs, w_hs;

  always_comb begin
    wstate_d      = wstate_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        s_axi_awready = !s_areset;
        aw_hs         = !s_areset && s_axi_awvalid;
        if (aw_hs) wstate_d = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        w_hs         = s_axi_wvalid;
        if (w_hs && (s_axi_wlast || wcnt_q == awlen_q)) wstate_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      wstate_q  <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wcnt_q    <= '0;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) begin
        awid_q    <= s_axi_awid;
        waddr_q   <= s_axi_awaddr;
        awlen_q   <= s_axi_awlen;
        awsize_q  <= s_axi_awsize;
        awburst_q <= s_axi_awburst;
        wcnt_q    <= '0;
      end else if (w_hs) begin
        waddr_q <= next_addr(waddr_q, awlen_q, awsize_q, awburst_q);
        wcnt_q  <= wcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge s_aclk) begin
    if (w_hs)
      for (int b = 0; b < SB; b++)
        if (s_axi_wstrb[b]) mem_q[waddr_q[AW-1:LB]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  end

  assign s_axi_bid   = awid_q;
  assign s_axi_bresp = 2'b00;

  rstate_e                rstate_q, rstate_d;
  logic [G_ID_WIDTH-1:0]  arid_q;
  logic [AW-1:0]          raddr_q, raddr_nxt;
  logic [7:0]             arlen_q, rcnt_q;
  logic [2:0]             arsize_q;
  logic [1:0]             arburst_q;
  logic [G_DATAWIDTH-1:0] rdata_q;
  logic                   ar_hs, r_hs;

  assign raddr_nxt = next_addr(raddr_q, arlen_q, arsize_q, arburst_q);

  always_comb begin
    rstate_d      = rstate_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    ar_hs         = 1'b0;
    r_hs          = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        s_axi_arready = !s_areset;
        ar_hs         = !s_areset && s_axi_arvalid;
        if (ar_hs) rstate_d = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (rcnt_q == arlen_q);
        r_hs         = s_axi_rready;
        if (r_hs && s_axi_rlast) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // rdata is fetched at the handshake edge, so a same-cycle write to that word is not yet visible.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      rstate_q  <= R_IDLE;
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        arid_q    <= s_axi_arid;
        raddr_q   <= s_axi_araddr;
        arlen_q   <= s_axi_arlen;
        arsize_q  <= s_axi_arsize;
        arburst_q <= s_axi_arburst;
        rcnt_q    <= '0;
        rdata_q   <= mem_q[s_axi_araddr[AW-1:LB]];
      end else if (r_hs && !s_axi_rlast) begin
        raddr_q <= raddr_nxt;
        rcnt_q  <= rcnt_q + 8'd1;
        rdata_q <= mem_q[raddr_nxt[AW-1:LB]];
      end
    end
  end

  assign s_axi_rid   = arid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = 2'b00;

endmodule

// File: tb/tb_axi_2p_mem.sv
// Randomised bench for axi_2p_mem against a byte-array reference model.
module tb_axi_2p_mem;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        s_aclk = 1'b0;
  logic        s_areset;
  logic [3:0]  s_axi_awid;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_arid;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid, s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  axi_2p_mem dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 s_aclk = ~s_aclk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mdl [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte address of beat i, computed directly from the burst definition.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] start, input int len,
                                              input int size, input int burst, input int i);
    int incr = 1 << size;
    int span = (len + 1) * incr;
    int st   = int'(start);
    int base;
    if (burst == 0) return start;
    if (burst == 2) begin
      base = (st / span) * span;
      return AW'(base + ((st - base + i * incr) % span));
    end
    return AW'((st + i * incr) % DEPTH);
  endfunction

  function automatic logic [31:0] mdl_word(input logic [AW-1:0] a);
    int w = (int'(a) / 4) * 4;
    return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic do_write(input logic [3:0] id, input logic [AW-1:0] addr, input int len,
                          input int size, input int burst, input int nbeats, input int dmode,
                          input logic [31:0] d0, input logic [3:0] strb, input int bdelay);
    int g;
    logic [31:0] d;
    logic [3:0] s;
    logic [AW-1:0] a;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst); s_axi_awvalid = 1'b1;
    g = 0;
    while (!s_axi_awready && g < 50) begin @(negedge s_aclk); g++; end
    check("aw_wait", 64'(g < 50), 64'd1);
    @(negedge s_aclk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (dmode == 1 && $urandom_range(3) == 0) begin
        s_axi_wvalid = 1'b0;
        @(negedge s_aclk);
      end
      d = (dmode == 0) ? d0 + 32'(i) : $urandom;
      s = (dmode == 0) ? strb : 4'($urandom);
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
      g = 0;
      while (!s_axi_wready && g < 50) begin @(negedge s_aclk); g++; end
      check("w_wait", 64'(g < 50), 64'd1);
      a = beat_addr(addr, len, size, burst, i);
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[(int'(a) / 4) * 4 + b] = d[b*8 +: 8];
      @(negedge s_aclk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("wready_resp", 64'(s_axi_wready), 64'd0);
    g = 0;
    while (!s_axi_bvalid && g < 50) begin @(negedge s_aclk); g++; end
    check("b_wait", 64'(g < 50), 64'd1);
    check("bid", 64'(s_axi_bid), 64'(id));
    check("bresp", 64'(s_axi_bresp), 64'd0);
    for (int k = 0; k < bdelay; k++) begin
      @(negedge s_aclk);
      check("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
    end
    s_axi_bready = 1'b1;
    @(negedge s_aclk);
    s_axi_bready = 1'b0;
    check("bvalid_clr", 64'(s_axi_bvalid), 64'd0);
    check("awready_back", 64'(s_axi_awready), 64'd1);
  endtask

  // rmode: 0 rready always high, 1 toggles every cycle, 2 random.
  task automatic do_read(input logic [3:0] id, input logic [AW-1:0] addr, input int len,
                         input int size, input int burst, input int rmode);
    int g, beat, cyc;
    logic rr;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arvalid = 1'b1;
    g = 0;
    while (!s_axi_arready && g < 50) begin @(negedge s_aclk); g++; end
    check("ar_wait", 64'(g < 50), 64'd1);
    @(negedge s_aclk);
    s_axi_arvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= len && cyc < 2000) begin
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : ($urandom_range(1) == 1);
      s_axi_rready = rr;
      check("rvalid", 64'(s_axi_rvalid), 64'd1);
      check("rdata", 64'(s_axi_rdata), 64'(mdl_word(beat_addr(addr, len, size, burst, beat))));
      check("rid", 64'(s_axi_rid), 64'(id));
      check("rlast", 64'(s_axi_rlast), 64'(beat == len));
      check("rresp", 64'(s_axi_rresp), 64'd0);
      if (rr) beat++;
      cyc++;
      @(negedge s_aclk);
    end
    s_axi_rready = 1'b0;
    check("rvalid_end", 64'(s_axi_rvalid), 64'd0);
    check("arready_back", 64'(s_axi_arready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 64'(s_axi_awready), 64'd0);
    check({tag, "_wready"},  64'(s_axi_wready),  64'd0);
    check({tag, "_bvalid"},  64'(s_axi_bvalid),  64'd0);
    check({tag, "_arready"}, 64'(s_axi_arready), 64'd0);
    check({tag, "_rvalid"},  64'(s_axi_rvalid),  64'd0);
    check({tag, "_rlast"},   64'(s_axi_rlast),   64'd0);
    check({tag, "_bid"},     64'(s_axi_bid),     64'd0);
    check({tag, "_rid"},     64'(s_axi_rid),     64'd0);
    check({tag, "_rdata"},   64'(s_axi_rdata),   64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    int rb, rs, rl;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    s_areset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge s_aclk);
    s_areset = 1'b0;
    #1;
    check("por_awready", 64'(s_axi_awready), 64'd1);
    check("por_arready", 64'(s_axi_arready), 64'd1);
    @(negedge s_aclk);

    // Unwritten memory reads back as zero.
    do_read(4'h1, 10'h3C0, 3, 2, 1, 0);
    // Single write then read.
    do_write(4'h3, 10'h010, 0, 2, 1, 1, 0, 32'hDEADBEEF, 4'hF, 0);
    do_read(4'h4, 10'h010, 0, 2, 1, 0);
    // INCR burst of 8.
    do_write(4'h2, 10'h100, 7, 2, 1, 8, 0, 32'd0, 4'hF, 0);
    do_read(4'h6, 10'h100, 7, 2, 1, 0);
    // Byte strobes.
    do_write(4'h8, 10'h020, 0, 2, 1, 1, 0, 32'hFFFFFFFF, 4'hF, 0);
    do_write(4'h8, 10'h020, 0, 2, 1, 1, 0, 32'h00000000, 4'h5, 0);
    do_read(4'h8, 10'h020, 0, 2, 1, 0);
    // Backpressure on R and B.
    do_read(4'hA, 10'h100, 7, 2, 1, 1);
    do_write(4'hB, 10'h0C0, 1, 2, 1, 2, 0, 32'h12340000, 4'hF, 5);
    // Early wlast cuts the burst short.
    do_write(4'h7, 10'h080, 7, 2, 1, 3, 0, 32'h80, 4'hF, 0);
    do_read(4'h7, 10'h080, 7, 2, 1, 0);
    // Concurrent write and read bursts issued in the same cycle.
    do_write(4'h0, 10'h300, 7, 2, 1, 8, 0, 32'h3000, 4'hF, 0);
    fork
      do_write(4'h5, 10'h200, 7, 2, 1, 8, 0, 32'h2000, 4'hF, 0);
      do_read(4'h9, 10'h300, 7, 2, 1, 0);
    join
    do_read(4'hC, 10'h200, 7, 2, 1, 2);
    // WRAP read starting at the top of a 16-byte window.
    do_write(4'h1, 10'h000, 3, 2, 1, 4, 0, 32'hA0, 4'hF, 0);
    do_read(4'hD, 10'h00C, 3, 2, 2, 0);

    // Reset while a read and a write burst are both in flight.
    s_axi_arid = 4'h2; s_axi_araddr = 10'h100; s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
    s_axi_awid = 4'h6; s_axi_awaddr = 10'h040; s_axi_awlen = 8'd3; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'd1; s_axi_awvalid = 1'b1;
    @(negedge s_aclk);
    s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    s_axi_rready = 1'b1;
    s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    check("mid_wready", 64'(s_axi_wready), 64'd1);
    check("mid_rvalid", 64'(s_axi_rvalid), 64'd1);
    {mdl[16'h43], mdl[16'h42], mdl[16'h41], mdl[16'h40]} = 32'hCAFEF00D;
    @(negedge s_aclk);
    s_axi_wvalid = 1'b0; s_axi_rready = 1'b0;
    #2 s_areset = 1'b1;
    #1 check_reset_outputs("mid");
    @(negedge s_aclk);
    s_areset = 1'b0;
    #1;
    check("rst_awready", 64'(s_axi_awready), 64'd1);
    check("rst_arready", 64'(s_axi_arready), 64'd1);
    @(negedge s_aclk);
    do_read(4'h3, 10'h040, 3, 2, 1, 0);
    do_read(4'h4, 10'h100, 7, 2, 1, 2);

    // Random mix of bursts, sizes and strobes.
    for (int t = 0; t < 40; t++) begin
      rb = $urandom_range(3);
      rs = $urandom_range(2);
      rl = (rb == 2) ? (2 << $urandom_range(3)) - 1 : $urandom_range(15);
      ra = AW'($urandom) & ~AW'((1 << rs) - 1);
      if ($urandom_range(1) == 1)
        do_write(4'($urandom), ra, rl, rs, rb, rl + 1, 1, 32'd0, 4'h0, $urandom_range(3));
      else
        do_read(4'($urandom), ra, rl, rs, rb, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
